// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse-driven grid painter.
// Grid geometry, address width and controller state encoding.
package mouse_pkg;

  localparam int GRID_W     = 10;
  localparam int GRID_H     = 10;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W     = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a
// rising-edge detector that yields a one-cycle press pulse.
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // next values: shift the raw button down the sync chain
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // synchronizer and edge-history flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign press_o = sync2_q & ~prev_q;

endmodule

// File: rtl/mouse_grid_ctrl.sv
// Grid RAM write controller: paints the cursor cell on left
// click, clears the whole grid on right click, drives motion LEDs.
module mouse_grid_ctrl #(
  parameter int GRID_W      = mouse_pkg::GRID_W,
  parameter int GRID_H      = mouse_pkg::GRID_H,
  parameter int MOTION_HOLD = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  bin_x,
  input  logic [3:0]                  bin_y,
  input  logic                        button_left,
  input  logic                        button_right,
  input  logic                        mem_gnt,
  output logic                        mem_req,
  output logic                        wr_en,
  output logic [mouse_pkg::ADDR_W-1:0] wr_addr,
  output logic                        wr_data,
  output logic                        busy,
  output logic                        clear_done,
  output logic                        motion_led,
  output logic                        idle_led
);

  import mouse_pkg::*;

  localparam int CELLS = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);
  localparam int MW = $clog2(MOTION_HOLD + 1);

  logic press_l, press_r;

  btn_edge u_btn_l (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (button_left),
    .press_o (press_l)
  );

  btn_edge u_btn_r (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (button_right),
    .press_o (press_r)
  );

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              data_q, data_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [3:0]        bx_q, bx_d;
  logic [3:0]        by_q, by_d;
  logic [MW-1:0]     cnt_q, cnt_d;

  logic [ADDR_W-1:0] cell_addr;
  logic              in_range;
  logic              moved;

  assign cell_addr = ADDR_W'(32'(bin_y) * GRID_W + 32'(bin_x));
  assign in_range  = (32'(bin_x) < GRID_W) && (32'(bin_y) < GRID_H);

  // controller next state: accept clicks, step the write sequence
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_r) begin
          state_d = CLEAR;
          addr_d  = '0;
          data_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (press_l && in_range) begin
          state_d = PAINT;
          addr_d  = cell_addr;
          data_d  = 1'b1;
        end
      end
      PAINT: begin
        if (press_r) pend_d = 1'b1;
        if (mem_gnt) begin
          if (press_r || pend_q) begin
            state_d = CLEAR;
            addr_d  = '0;
            data_d  = 1'b0;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CLEAR: begin
        pend_d = 1'b0;
        if (mem_gnt) begin
          if (addr_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // motion detect: any bin change restarts the LED stretch
  always_comb begin
    bx_d  = bin_x;
    by_d  = bin_y;
    moved = (bin_x != bx_q) || (bin_y != by_q);
    if (moved)
      cnt_d = MW'(MOTION_HOLD);
    else if (cnt_q != '0)
      cnt_d = cnt_q - MW'(1);
    else
      cnt_d = '0;
  end

  // all controller and motion state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      bx_q    <= '0;
      by_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign mem_req    = busy;
  assign wr_en      = mem_req & mem_gnt;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign clear_done = done_q;
  assign motion_led = (cnt_q != '0);
  assign idle_led   = ~motion_led;

endmodule

// File: tb/tb_mouse_grid_ctrl.sv
// Bench for mouse_grid_ctrl: table vectors, directed sequences
// and random traffic against a transaction-level write model.
module tb_mouse_grid_ctrl;

  localparam int HOLD  = 8;
  localparam int CELLS = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] bin_x, bin_y;
  logic       button_left, button_right, mem_gnt;
  logic       mem_req, wr_en, wr_data, busy;
  logic       clear_done, motion_led, idle_led;
  logic [6:0] wr_addr;

  mouse_grid_ctrl #(
    .GRID_W      (10),
    .GRID_H      (10),
    .MOTION_HOLD (HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bin_x        (bin_x),
    .bin_y        (bin_y),
    .button_left  (button_left),
    .button_right (button_right),
    .mem_gnt      (mem_gnt),
    .mem_req      (mem_req),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .clear_done   (clear_done),
    .motion_led   (motion_led),
    .idle_led     (idle_led)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  int ncmp = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [6:0] a;
    logic       d;
  } wr_t;

  // expected outstanding writes; empty means idle
  wr_t  mq[$];
  wr_t  wlog[$];
  bit   pend;
  bit   hl1, hl2, hl3, hr1, hr2, hr3;
  logic [3:0] pbx, pby;
  int   cyc, last_load;
  bit   exp_done;
  int   ndone, nbusy, nled;

  task automatic model_reset();
    mq.delete();
    pend = 0;
    {hl1, hl2, hl3, hr1, hr2, hr3} = '0;
    pbx = '0;
    pby = '0;
    last_load = -1000;
    exp_done = 0;
  endtask

  task automatic push_clear();
    for (int i = 0; i < CELLS; i++)
      mq.push_back('{a: 7'(i), d: 1'b0});
  endtask

  task automatic model_check(input bit gnt);
    bit b;
    bit led;
    b = (mq.size() != 0);
    led = (cyc - last_load >= 1) && (cyc - last_load <= HOLD);
    chk("busy", busy, b);
    chk("mem_req", mem_req, b);
    chk("wr_en", wr_en, b & gnt);
    chk("clear_done", clear_done, exp_done);
    chk("motion_led", motion_led, led);
    chk("idle_led", idle_led, !led);
    if (b) begin
      chk("wr_addr", wr_addr, mq[0].a);
      chk("wr_data", wr_data, mq[0].d);
    end
  endtask

  task automatic model_step(input logic [3:0] bx, by,
                            input bit bl, br, gnt);
    bit  pl, pr;
    wr_t f;
    pl = hl2 & ~hl3;
    pr = hr2 & ~hr3;
    exp_done = 0;
    if (mq.size() == 0) begin
      if (pr)
        push_clear();
      else if (pl && bx < 10 && by < 10)
        mq.push_back('{a: 7'(int'(by) * 10 + int'(bx)), d: 1'b1});
    end else if (mq[0].d) begin
      if (pr) pend = 1;
      if (gnt) begin
        void'(mq.pop_front());
        if (pend) begin
          push_clear();
          pend = 0;
        end
      end
    end else if (gnt) begin
      f = mq.pop_front();
      if (f.a == 7'(CELLS - 1)) exp_done = 1;
    end
    if (bx != pbx || by != pby) last_load = cyc;
    pbx = bx;
    pby = by;
    hl3 = hl2; hl2 = hl1; hl1 = bl;
    hr3 = hr2; hr2 = hr1; hr1 = br;
    cyc++;
  endtask

  // one clock: drive at negedge, check, advance model, pass posedge
  task automatic step(input logic [3:0] bx, by,
                      input bit bl, br, gnt);
    @(negedge clk);
    bin_x = bx;
    bin_y = by;
    button_left = bl;
    button_right = br;
    mem_gnt = gnt;
    #1;
    model_check(gnt);
    if (wr_en) wlog.push_back('{a: wr_addr, d: wr_data});
    if (clear_done) ndone++;
    if (busy) nbusy++;
    if (motion_led) nled++;
    model_step(bx, by, bl, br, gnt);
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bin_x = '0;
    bin_y = '0;
    button_left = 1'b0;
    button_right = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_motion_led", motion_led, 0);
    chk("rst_idle_led", idle_led, 1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] bx;
    logic [3:0] by;
    bit         acc;
    int         addr;
  } vec_t;

  vec_t tbl[8];
  int   nord;
  bit   found;
  logic [3:0] rx, ry;

  initial begin
    reset_n = 1'b0;
    bin_x = '0;
    bin_y = '0;
    button_left = 1'b0;
    button_right = 1'b0;
    mem_gnt = 1'b0;
    cyc = 0;
    model_reset();
    #1;
    chk("init_mem_req", mem_req, 0);
    chk("init_wr_en", wr_en, 0);
    chk("init_busy", busy, 0);
    chk("init_wr_addr", wr_addr, 0);
    chk("init_wr_data", wr_data, 0);
    chk("init_clear_done", clear_done, 0);
    chk("init_motion_led", motion_led, 0);
    chk("init_idle_led", idle_led, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    tbl[0] = '{4'd3, 4'd4, 1'b1, 43};
    tbl[1] = '{4'd12, 4'd2, 1'b0, 0};
    tbl[2] = '{4'd9, 4'd9, 1'b1, 99};
    tbl[3] = '{4'd0, 4'd0, 1'b1, 0};
    tbl[4] = '{4'd10, 4'd0, 1'b0, 0};
    tbl[5] = '{4'd0, 4'd10, 1'b0, 0};
    tbl[6] = '{4'd15, 4'd15, 1'b0, 0};
    tbl[7] = '{4'd9, 4'd0, 1'b1, 9};

    foreach (tbl[k]) begin
      wlog.delete();
      step(tbl[k].bx, tbl[k].by, 1, 0, 0);
      step(tbl[k].bx, tbl[k].by, 0, 0, 0);
      step(tbl[k].bx, tbl[k].by, 0, 0, 0);
      #2;
      chk("tbl_busy", busy, tbl[k].acc);
      chk("tbl_mem_req", mem_req, tbl[k].acc);
      if (tbl[k].acc) begin
        chk("tbl_addr", wr_addr, tbl[k].addr);
        chk("tbl_data", wr_data, 1);
      end
      step(tbl[k].bx, tbl[k].by, 0, 0, 1);
      step(tbl[k].bx, tbl[k].by, 0, 0, 0);
      #2;
      chk("tbl_back_idle", busy, 0);
      chk("tbl_nwrites", wlog.size(), tbl[k].acc ? 1 : 0);
    end

    // full clear with grant toggling every cycle
    do_reset();
    wlog.delete();
    ndone = 0;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    nbusy = 0;
    for (int i = 0; i < 199; i++) step(0, 0, 0, 0, (i % 2) == 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("clr_busy_cycles", nbusy, 199);
    chk("clr_nwrites", wlog.size(), CELLS);
    chk("clr_ndone", ndone, 1);
    nord = 0;
    foreach (wlog[i])
      if (wlog[i].a != 7'(i) || wlog[i].d != 1'b0) nord++;
    chk("clr_order", nord, 0);

    // paint stalled, right click queued behind it
    wlog.delete();
    step(3, 4, 1, 0, 0);
    step(3, 4, 0, 0, 0);
    step(3, 4, 0, 0, 0);
    step(3, 4, 0, 1, 0);
    step(3, 4, 0, 0, 0);
    step(3, 4, 0, 0, 0);
    step(3, 4, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      step(3, 4, 0, 0, 1);
      #2;
      if (!busy) begin
        found = 1;
        break;
      end
    end
    chk("pend_finished", found, 1);
    chk("pend_nwrites", wlog.size(), CELLS + 1);
    if (wlog.size() == CELLS + 1) begin
      chk("pend_paint_addr", wlog[0].a, 43);
      chk("pend_paint_data", wlog[0].d, 1);
      chk("pend_first_clr", wlog[1].a, 0);
      chk("pend_last_clr", wlog[CELLS].a, CELLS - 1);
    end

    // reset in the middle of a clear
    step(0, 0, 0, 1, 0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (busy && wr_addr == 7'd50) begin
        found = 1;
        break;
      end
      step(0, 0, 0, 0, 1);
    end
    chk("mid_clear_reached", found, 1);
    do_reset();
    wlog.delete();
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
    chk("post_rst_writes", wlog.size(), 0);

    // motion stretch
    for (int i = 0; i < 12; i++) step(2, 0, 0, 0, 0);
    nled = 0;
    for (int i = 0; i < 15; i++) step(3, 0, 0, 0, 0);
    chk("motion_cycles", nled, HOLD);

    // random traffic
    rx = 4'd3;
    ry = 4'd4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 15) == 0) rx = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 15) == 0) ry = 4'($urandom_range(0, 11));
      step(rx, ry, $urandom_range(0, 5) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/mouse_grid_ctrl.md
MOUSE_GRID_CTRL -- requirements
Module: mouse_grid_ctrl

Interface
REQ-001 SHALL have parameter GRID_W, default 10, grid columns.
REQ-002 SHALL have parameter GRID_H, default 10, grid rows.
REQ-003 SHALL have parameter MOTION_HOLD, default 5_000_000, motion LED stretch in clk cycles.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports bin_x, bin_y  input  4 each  cursor cell from the PS/2 mouse bin logic.
REQ-007 SHALL have ports button_left, button_right  input  1 each  raw, asynchronous mouse buttons.
REQ-008 SHALL have port mem_gnt  input  1  grid RAM write grant from the display-side arbiter.
REQ-009 SHALL have port mem_req  output  1  grid RAM write request.
REQ-010 SHALL have port wr_en  output  1  write strobe, equal to mem_req AND mem_gnt (combinational).
REQ-011 SHALL have port wr_addr  output  7  cell address, bin_y*GRID_W + bin_x.
REQ-012 SHALL have port wr_data  output  1  cell value: 1 paint, 0 clear.
REQ-013 SHALL have ports busy, clear_done, motion_led, idle_led  output  1 each  status.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer, then a rising-edge detector (1-cycle press pulse).
REQ-015 SHALL implement FSM states IDLE, PAINT, CLEAR.
REQ-016 IDLE: left press with bin_x<GRID_W and bin_y<GRID_H SHALL latch wr_addr, set wr_data=1, go to PAINT.
REQ-017 IDLE: left press out of range SHALL be ignored; state stays IDLE.
REQ-018 IDLE: right press SHALL set wr_addr=0, wr_data=0, go to CLEAR.
REQ-019 IDLE: left and right press in the same cycle SHALL go to CLEAR (right wins).
REQ-020 PAINT: mem_req=1, address/data held; on the cycle mem_req AND mem_gnt, SHALL return to IDLE next cycle.
REQ-021 PAINT: left press SHALL be ignored; right press SHALL set clear_pending; PAINT exit with clear_pending SHALL go to CLEAR, not IDLE.
REQ-022 CLEAR: mem_req=1; each granted cycle SHALL increment wr_addr; grant at address GRID_W*GRID_H-1 SHALL go to IDLE and pulse clear_done for exactly 1 cycle.
REQ-023 CLEAR: all button presses SHALL be ignored; clear_pending SHALL be cleared on CLEAR entry.
REQ-024 mem_gnt low SHALL stall any state with no address change; mem_gnt in IDLE SHALL have no effect.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 wr_addr SHALL be computed in 7 bits, never exceeding GRID_W*GRID_H-1 (GRID_W*GRID_H <= 128).
REQ-027 bin_x/bin_y SHALL be registered each cycle; any change versus the previous value SHALL reload a motion counter with MOTION_HOLD.
REQ-028 motion_led SHALL be 1 while the counter is nonzero; counter SHALL decrement to 0 and saturate; idle_led SHALL equal NOT motion_led.

Reset
REQ-029 reset_n low SHALL asynchronously force state IDLE, synchronizers/edge flops 0, clear_pending 0, wr_addr 0, wr_data 0, motion counter 0, previous bins 0.
REQ-030 Under reset outputs SHALL be mem_req=0, wr_en=0, busy=0, clear_done=0, motion_led=0, idle_led=1.
REQ-031 Reset asserted mid-PAINT or mid-CLEAR SHALL abandon the operation; no write SHALL be issued after release without a new press.

Structure
REQ-032 A shared package mouse_pkg SHALL hold the FSM state enum and constants GRID_W, GRID_H, GRID_CELLS, ADDR_W=7.
REQ-033 One sub-module btn_edge (2-flop synchronizer + rising-edge detector) SHALL be instantiated once per button.

Verification
REQ-034 bin=(3,4), left press, mem_gnt=1 -> one wr_en pulse, wr_addr=43, wr_data=1, then IDLE, busy=0.
REQ-035 bin=(12,2), left press -> no mem_req, state stays IDLE.
REQ-036 Right press, mem_gnt toggling 1/0 each cycle -> 100 wr_en pulses, addresses 0..99 in order, wr_data=0, one clear_done, 199 cycles from first request.
REQ-037 Left press with mem_gnt=0, right press 3 cycles later, then mem_gnt=1 -> paint write at latched address, then full 100-cell clear.
REQ-038 reset_n low at CLEAR address 50 for 2 cycles -> mem_req=0 immediately, wr_addr=0, no further writes after release.
REQ-039 MOTION_HOLD=8, bin_x 2->3 once -> motion_led=1 for 8 cycles, then 0, idle_led the inverse throughout.
